// File: rtl/tank_pkg.sv
// Shared types and constants for the tank game: shell FSM states, screen size
// and the terrain curve coefficients used by shells, tanks and the renderer.
package tank_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FLIGHT,
      EXPLODE
   } shell_state_t;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   // ground(x) = TERR_QA*x*x/TERR_QD - TERR_LA*x/TERR_LD + TERR_C
   localparam int unsigned TERR_QA = 607;
   localparam int unsigned TERR_QD = 1562500;
   localparam int unsigned TERR_LA = 71;
   localparam int unsigned TERR_LD = 500;
   localparam int unsigned TERR_C  = 267;

endpackage

// File: rtl/terrain_height.sv
// Combinational terrain curve: ground height in pixels for a screen column.
module terrain_height
   import tank_pkg::*;
(
   input  logic [9:0] x,
   output logic [9:0] height
);

   logic [31:0] x32;
   logic [31:0] quad;
   logic [31:0] lin;

   // Each term truncates on its own, so the sum can be negative-free only
   // because the quadratic plus the constant always exceeds the linear term.
   always_comb begin
      x32    = {22'd0, x};
      quad   = (TERR_QA * x32 * x32) / TERR_QD;
      lin    = (TERR_LA * x32) / TERR_LD;
      height = 10'(quad + TERR_C - lin);
   end

endmodule

// File: rtl/tank_shell.sv
// One tank's shell: launch on shoot, per-frame ballistic integration with
// gravity, enemy/off-screen/ground checks, and a fixed-length explosion.
module tank_shell
   import tank_pkg::*;
#(
   parameter int VX_SPEED       = 3,
   parameter int VY_MAX         = 12,
   parameter int GRAV_DIV       = 4,
   parameter int MUZZLE_DY      = 8,
   parameter int SHELL_R        = 2,
   parameter int EXPLODE_FRAMES = 16
)(
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       shoot,
   input  logic [9:0] TankX,
   input  logic [9:0] TankY,
   input  logic [1:0] Direction,
   input  logic [9:0] y_component,
   input  logic [9:0] EnemyX,
   input  logic [9:0] EnemyY,
   input  logic [9:0] EnemyS,
   output logic [9:0] ShellX,
   output logic [9:0] ShellY,
   output logic       ShellActive,
   output logic       Exploding,
   output logic       hit
);

   localparam logic signed [5:0]  VX_S     = 6'(VX_SPEED);
   localparam logic signed [5:0]  VY_LIM   = 6'(VY_MAX);
   localparam logic signed [9:0]  VY_LIM10 = 10'(VY_MAX);
   localparam logic signed [10:0] X_MAX    = 11'(SCREEN_W - 1);
   localparam logic signed [10:0] Y_MAX    = 11'(SCREEN_H - 1);
   localparam logic [4:0]         GRAV_TOP = 5'(GRAV_DIV - 1);
   localparam logic [4:0]         EXPL_TOP = 5'(EXPLODE_FRAMES - 1);

   shell_state_t      state_q, state_d;
   logic signed [10:0] px_q, px_d, py_q, py_d;
   logic signed [5:0]  vx_q, vx_d, vy_q, vy_d;
   logic [4:0]         grav_q, grav_d, expl_q, expl_d;
   logic               hit_q, hit_d;

   logic signed [10:0] nx, ny;
   logic [11:0]        dx, dy, adx, ady, reach;
   logic [9:0]         gnd;
   logic               hit_now, off_now, gnd_now;

   // Aim is negated so a larger y_component launches upward (negative vy).
   function automatic logic signed [5:0] launch_vy(input logic [9:0] yc_raw);
      logic signed [9:0] yc;
      yc = signed'(yc_raw);
      if (yc > VY_LIM10)       return -VY_LIM;
      else if (yc < -VY_LIM10) return VY_LIM;
      else                     return -(6'(yc));
   endfunction

   assign nx = px_q + {{5{vx_q[5]}}, vx_q};
   assign ny = py_q + {{5{vy_q[5]}}, vy_q};

   terrain_height u_terrain (
      .x      (nx[9:0]),
      .height (gnd)
   );

   assign dx      = {nx[10], nx} - {2'b00, EnemyX};
   assign dy      = {ny[10], ny} - {2'b00, EnemyY};
   assign adx     = dx[11] ? (~dx + 12'd1) : dx;
   assign ady     = dy[11] ? (~dy + 12'd1) : dy;
   assign reach   = {2'b00, EnemyS} + 12'(SHELL_R);
   assign hit_now = (adx <= reach) && (ady <= reach);
   assign off_now = nx[10] || (nx > X_MAX) || (ny > Y_MAX);
   assign gnd_now = (ny >= $signed({1'b0, gnd}));

   always_comb begin
      state_d = state_q;
      px_d    = px_q;
      py_d    = py_q;
      vx_d    = vx_q;
      vy_d    = vy_q;
      grav_d  = grav_q;
      expl_d  = expl_q;
      hit_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (shoot) begin
               state_d = FLIGHT;
               px_d    = signed'({1'b0, TankX});
               py_d    = signed'({1'b0, TankY}) - 11'(MUZZLE_DY);
               vx_d    = (Direction == 2'd0) ? -VX_S : VX_S;
               vy_d    = launch_vy(y_component);
               grav_d  = 5'd0;
            end
         end
         FLIGHT: begin
            if (grav_q == GRAV_TOP) begin
               grav_d = 5'd0;
               vy_d   = (vy_q >= VY_LIM) ? VY_LIM : vy_q + 6'sd1;
            end else begin
               grav_d = grav_q + 5'd1;
            end
            if (hit_now) begin
               hit_d   = 1'b1;
               state_d = EXPLODE;
               expl_d  = 5'd0;
               px_d    = nx;
               py_d    = ny;
            end else if (off_now) begin
               state_d = IDLE;
            end else if (gnd_now) begin
               state_d = EXPLODE;
               expl_d  = 5'd0;
               px_d    = nx;
               py_d    = ny;
            end else begin
               px_d = nx;
               py_d = ny;
            end
         end
         EXPLODE: begin
            if (expl_q == EXPL_TOP) begin
               state_d = IDLE;
               expl_d  = 5'd0;
            end else begin
               expl_d = expl_q + 5'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q <= IDLE;
         px_q    <= '0;
         py_q    <= '0;
         vx_q    <= '0;
         vy_q    <= '0;
         grav_q  <= '0;
         expl_q  <= '0;
         hit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         px_q    <= px_d;
         py_q    <= py_d;
         vx_q    <= vx_d;
         vy_q    <= vy_d;
         grav_q  <= grav_d;
         expl_q  <= expl_d;
         hit_q   <= hit_d;
      end
   end

   // Shells above the top edge are legal; the renderer just sees row 0.
   assign ShellX      = px_q[9:0];
   assign ShellY      = py_q[10] ? 10'd0 : py_q[9:0];
   assign ShellActive = (state_q == FLIGHT);
   assign Exploding   = (state_q == EXPLODE);
   assign hit         = hit_q;

endmodule

// File: tb/tb_tank_shell.sv
// Bench for tank_shell: an integer-arithmetic flight model checked every frame,
// plus hand-derived trajectory points for the directed scenarios.
module tb_tank_shell;

   logic       frame_clk = 1'b0;
   logic       Reset;
   logic       shoot;
   logic [9:0] TankX, TankY, y_component, EnemyX, EnemyY, EnemyS;
   logic [1:0] Direction;
   logic [9:0] ShellX, ShellY;
   logic       ShellActive, Exploding, hit;

   int checks   = 0;
   int failures = 0;
   int hit_seen = 0;
   logic prev_hit = 1'b0;

   // model state: 0 idle, 1 flight, 2 explode
   int m_state = 0, m_px = 0, m_py = 0, m_vx = 0, m_vy = 0, m_f = 0, m_e = 0;
   bit m_hit = 1'b0;

   tank_shell dut (
      .frame_clk   (frame_clk),
      .Reset       (Reset),
      .shoot       (shoot),
      .TankX       (TankX),
      .TankY       (TankY),
      .Direction   (Direction),
      .y_component (y_component),
      .EnemyX      (EnemyX),
      .EnemyY      (EnemyY),
      .EnemyS      (EnemyS),
      .ShellX      (ShellX),
      .ShellY      (ShellY),
      .ShellActive (ShellActive),
      .Exploding   (Exploding),
      .hit         (hit)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic int ground_f(input int x);
      longint xl;
      xl = x;
      return int'(607 * xl * xl / 1562500 - 71 * xl / 500 + 267);
   endfunction

   always @(posedge frame_clk or posedge Reset) begin
      int nx, ny, yc, ex, ey, es;
      if (Reset) begin
         m_state = 0; m_px = 0; m_py = 0; m_vx = 0; m_vy = 0;
         m_f = 0; m_e = 0; m_hit = 1'b0;
      end else begin
         m_hit = 1'b0;
         if (m_state == 0) begin
            if (shoot) begin
               m_state = 1;
               m_px = int'(TankX);
               m_py = int'(TankY) - 8;
               m_vx = (Direction == 2'd0) ? -3 : 3;
               yc = $signed(y_component);
               if (yc > 12) yc = 12;
               if (yc < -12) yc = -12;
               m_vy = -yc;
               m_f = 0;
            end
         end else if (m_state == 1) begin
            nx = m_px + m_vx;
            ny = m_py + m_vy;
            if ((m_f % 4) == 3 && m_vy < 12) m_vy = m_vy + 1;
            m_f = m_f + 1;
            ex = int'(EnemyX); ey = int'(EnemyY); es = int'(EnemyS);
            if (iabs(nx - ex) <= es + 2 && iabs(ny - ey) <= es + 2) begin
               m_hit = 1'b1; m_state = 2; m_e = 0; m_px = nx; m_py = ny;
            end else if (nx < 0 || nx > 639 || ny > 479) begin
               m_state = 0;
            end else if (ny >= ground_f(nx)) begin
               m_state = 2; m_e = 0; m_px = nx; m_py = ny;
            end else begin
               m_px = nx; m_py = ny;
            end
         end else begin
            m_e = m_e + 1;
            if (m_e == 16) m_state = 0;
         end
      end
   end

   always @(negedge frame_clk) begin
      check("active", int'(ShellActive), int'(m_state == 1));
      check("exploding", int'(Exploding), int'(m_state == 2));
      check("hit", int'(hit), int'(m_hit));
      check("hit_twice", int'(hit & prev_hit), 0);
      prev_hit = hit;
      if (hit) hit_seen++;
      if (m_state != 0) begin
         check("shell_x", int'(ShellX), m_px);
         check("shell_y", int'(ShellY), (m_py < 0) ? 0 : m_py);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge frame_clk);
         #2;
      end
   endtask

   task automatic launch(input int tx, input int ty, input int dir, input logic [9:0] yc);
      TankX = 10'(tx); TankY = 10'(ty); Direction = 2'(dir); y_component = yc;
      shoot = 1'b1;
      tick(1);
      shoot = 1'b0;
   endtask

   task automatic run_until_idle(input int maxf, input string nm);
      int n;
      n = 0;
      while ((ShellActive || Exploding) && n < maxf) begin
         tick(1);
         n++;
      end
      check(nm, int'(ShellActive | Exploding), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, hit_edge;
      Reset = 1'b1; shoot = 1'b0;
      TankX = '0; TankY = '0; Direction = '0; y_component = '0;
      EnemyX = 10'd600; EnemyY = 10'd50; EnemyS = 10'd4;
      #12 Reset = 1'b0;
      tick(10);
      check("rst_active", int'(ShellActive), 0);
      check("rst_hit", int'(hit), 0);
      check("rst_x", int'(ShellX), 0);
      check("rst_y", int'(ShellY), 0);

      // level shot to the right, lands on terrain at (175,258)
      hit_seen = 0;
      launch(100, 200, 1, 10'd0);
      check("launch_x", int'(ShellX), 100);
      check("launch_y", int'(ShellY), 192);
      check("launch_active", int'(ShellActive), 1);
      tick(3);
      check("flight_x3", int'(ShellX), 109);
      n = 0;
      while (!Exploding && n < 100) begin tick(1); n++; end
      check("ground_reached", int'(Exploding), 1);
      check("ground_x", int'(ShellX), 175);
      check("ground_y", int'(ShellY), 258);
      n = 0;
      while (Exploding && n < 40) begin n++; tick(1); end
      check("explode_frames", n, 16);
      check("ground_no_hit", hit_seen, 0);

      // enemy box reached when nx=106 (|106-112| = 6 = S+R)
      EnemyX = 10'd112; EnemyY = 10'd192; EnemyS = 10'd4;
      hit_seen = 0;
      launch(100, 200, 1, 10'd0);
      hit_edge = 0;
      for (int k = 1; k <= 10 && hit_edge == 0; k++) begin
         tick(1);
         if (hit) hit_edge = k;
      end
      check("hit_edge", hit_edge, 2);
      check("hit_x", int'(ShellX), 106);
      check("hit_y", int'(ShellY), 192);
      check("hit_exploding", int'(Exploding), 1);
      run_until_idle(40, "hit_done");
      check("hit_count", hit_seen, 1);
      EnemyX = 10'd600; EnemyY = 10'd50;

      // leftward shot leaves screen at nx=-1
      hit_seen = 0;
      launch(5, 200, 0, 10'd0);
      tick(1);
      check("left_active", int'(ShellActive), 1);
      check("left_x", int'(ShellX), 2);
      tick(1);
      check("left_gone", int'(ShellActive), 0);
      check("left_no_explode", int'(Exploding), 0);
      check("left_no_hit", hit_seen, 0);

      // shoot during flight and across the FLIGHT->IDLE edge is dropped
      launch(5, 200, 0, 10'd0);
      shoot = 1'b1;
      tick(2);
      shoot = 1'b0;
      check("ignore_active", int'(ShellActive), 0);
      tick(2);
      check("ignore_still_idle", int'(ShellActive), 0);
      launch(5, 200, 0, 10'd0);
      check("fresh_active", int'(ShellActive), 1);
      check("fresh_x", int'(ShellX), 5);
      tick(3);

      // asynchronous reset mid-flight
      hit_seen = 0;
      launch(100, 200, 1, 10'd0);
      tick(4);
      Reset = 1'b1;
      #1;
      check("arst_active", int'(ShellActive), 0);
      check("arst_x", int'(ShellX), 0);
      check("arst_y", int'(ShellY), 0);
      check("arst_hit", int'(hit), 0);
      tick(2);
      Reset = 1'b0;
      tick(1);
      check("arst_idle", int'(ShellActive), 0);
      check("arst_no_hit", hit_seen, 0);

      // downward aim (-10 -> vy=+10) hits ground at (121,265)
      launch(100, 200, 1, 10'h3F6);
      tick(1);
      check("down_y", int'(ShellY), 202);
      n = 0;
      while (!Exploding && n < 50) begin tick(1); n++; end
      check("down_x_imp", int'(ShellX), 121);
      check("down_y_imp", int'(ShellY), 265);
      run_until_idle(40, "down_done");

      // steep aim clamps to vy=-12 and climbs above the screen
      launch(100, 200, 1, 10'd20);
      tick(1);
      check("up_y1", int'(ShellY), 180);
      tick(19);
      check("up_clip_y", int'(ShellY), 0);
      check("up_clip_x", int'(ShellX), 160);
      check("up_clip_active", int'(ShellActive), 1);
      run_until_idle(400, "up_done");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
